// File: rtl/btn_pkg.sv
// Shared definitions for the push-button gesture path.
// Holds the FSM state encoding used by the event classifier and the default
// timing constants shared with the debouncer integration.
package btn_pkg;

  // 3-bit state encoding for the gesture classifier FSM.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_LONG   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PRESS2 = 3'd4
  } btn_state_t;

  // Default timing: 1 ms ticks at 50 MHz.
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_LONG_TICKS   = 800;
  localparam int DEF_DCLICK_TICKS = 250;
  localparam int DEF_TW           = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Timing tick prescaler for the gesture classifier.
// Counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   clr   - restart the count from 0 (state-change strobe from the FSM)
//   tick  - high while the count sits at TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = btn_pkg::DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running divider; clearing on clr makes every state's timing start
  // exactly at its entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/button_event_classifier.sv
// Push-button gesture classifier.
// Consumes debounced press/release strobes and reports short press, long
// press and double click as one-cycle pulses, plus a held level while a long
// press continues and a wrapping count of emitted events.
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   pos          - debounced press strobe (1 cycle)
//   neg          - debounced release strobe (1 cycle)
//   short_press  - pulse: single short press completed
//   long_press   - pulse: press held LONG_TICKS
//   double_click - pulse: second press released inside the window
//   held         - level: high while in the LONG state
//   ev_count     - 8-bit count of emitted events, wraps 255->0
module button_event_classifier
  import btn_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
  parameter int TW           = DEF_TW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pos,
  input  logic       neg,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic       held,
  output logic [7:0] ev_count
);

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_TICKS - 1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_TICKS - 1);

  btn_state_t    state;
  btn_state_t    state_next;
  logic [TW-1:0] timer;
  logic          tick;
  logic          state_chg;
  logic          press;
  logic          release_ev;
  logic          long_to;
  logic          dclick_to;
  logic          short_nx;
  logic          long_nx;
  logic          dclick_nx;

  // Simultaneous press and release strobes are treated as noise.
  assign press      = pos & ~neg;
  assign release_ev = neg & ~pos;

  assign long_to    = tick && (timer == LONG_LAST);
  assign dclick_to  = tick && (timer == DCLICK_LAST);
  assign state_chg  = (state_next != state);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_chg),
    .tick (tick)
  );

  // Next-state and event decode; strobes are tested before timeouts so an
  // edge wins when both land in the same cycle.
  always_comb begin
    state_next = state;
    short_nx   = 1'b0;
    long_nx    = 1'b0;
    dclick_nx  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (press) state_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (release_ev) begin
          state_next = ST_GAP;
        end else if (long_to) begin
          state_next = ST_LONG;
          long_nx    = 1'b1;
        end
      end
      ST_LONG: begin
        if (release_ev) state_next = ST_IDLE;
      end
      ST_GAP: begin
        if (press) begin
          state_next = ST_PRESS2;
        end else if (dclick_to) begin
          state_next = ST_IDLE;
          short_nx   = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (release_ev) begin
          state_next = ST_IDLE;
          dclick_nx  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and per-state timer; the timer restarts on every
  // transition and sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      if (state_chg) begin
        timer <= '0;
      end else if (tick && (timer != '1)) begin
        timer <= timer + TW'(1);
      end
    end
  end

  // Registered outputs; the counter advances in the same edge that raises a
  // pulse so both are visible together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      held         <= 1'b0;
      ev_count     <= 8'd0;
    end else begin
      short_press  <= short_nx;
      long_press   <= long_nx;
      double_click <= dclick_nx;
      held         <= (state_next == ST_LONG);
      if (short_nx || long_nx || dclick_nx) begin
        ev_count <= ev_count + 8'd1;
      end
    end
  end

endmodule
